// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcodes, flag bit indices and FSM encoding for alu_seq
package alu_seq_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] OP_ADD  = 4'd2;
   localparam logic [3:0] OP_ADDC = 4'd3;
   localparam logic [3:0] OP_SUB  = 4'd4;
   localparam logic [3:0] OP_SUBC = 4'd5;
   localparam logic [3:0] OP_NOR  = 4'd6;
   localparam logic [3:0] OP_NAND = 4'd7;
   localparam logic [3:0] OP_XOR  = 4'd8;
   localparam logic [3:0] OP_XNOR = 4'd9;
   localparam logic [3:0] OP_MUL  = 4'd10;
   localparam logic [3:0] OP_SHL  = 4'd11;
   localparam logic [3:0] OP_SHR  = 4'd12;
   localparam logic [3:0] OP_ASR  = 4'd13;
   localparam logic [3:0] OP_ROL  = 4'd14;

   localparam int FLG_C = 0;
   localparam int FLG_V = 1;
   localparam int FLG_Z = 2;
   localparam int FLG_N = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MUL   = 2'd1,
      ST_SHIFT = 2'd2
   } state_t;

endpackage

// File: rtl/alu_seq_iter.sv
// rtl/alu_seq_iter.sv - iterative shift-add multiply and one-bit-per-cycle shift engine
module alu_iter_unit
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4,
   parameter int CNT_W = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             i_load,
   input  logic             i_step,
   input  logic [OP_W-1:0]  i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [CNT_W-1:0] i_cnt,
   output logic [WIDTH-1:0] o_nxt_hi,
   output logic [WIDTH-1:0] o_nxt_lo,
   output logic             o_nxt_out,
   output logic             o_last
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;
   logic [WIDTH-1:0] r_b;
   logic [OP_W-1:0]  r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH:0]   w_sum;

   // Multiply: {hi,lo} shifts right, multiplier bits consumed from lo[0].
   always_comb begin
      o_nxt_hi  = r_hi;
      o_nxt_lo  = r_lo;
      o_nxt_out = 1'b0;
      w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
      case (r_op)
         OP_MUL: begin
            o_nxt_hi = w_sum[WIDTH:1];
            o_nxt_lo = {w_sum[0], r_lo[WIDTH-1:1]};
         end
         OP_SHL: begin
            o_nxt_lo  = {r_lo[WIDTH-2:0], 1'b0};
            o_nxt_out = r_lo[WIDTH-1];
         end
         OP_SHR: begin
            o_nxt_lo  = {1'b0, r_lo[WIDTH-1:1]};
            o_nxt_out = r_lo[0];
         end
         OP_ASR: begin
            o_nxt_lo  = {r_lo[WIDTH-1], r_lo[WIDTH-1:1]};
            o_nxt_out = r_lo[0];
         end
         OP_ROL: begin
            o_nxt_lo  = {r_lo[WIDTH-2:0], r_lo[WIDTH-1]};
            o_nxt_out = r_lo[WIDTH-1];
         end
         default: ;
      endcase
   end

   assign o_last = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_hi  <= '0;
         r_lo  <= '0;
         r_b   <= '0;
         r_op  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_hi  <= '0;
         r_lo  <= i_a;
         r_b   <= i_b;
         r_op  <= i_op;
         r_cnt <= i_cnt;
      end else if (i_step) begin
         r_hi  <= o_nxt_hi;
         r_lo  <= o_nxt_lo;
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - accumulator ALU with single-cycle ops and multi-cycle multiply/shift
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             start,
   input  logic [OP_W-1:0]  op,
   input  logic [WIDTH-1:0] operand,
   input  logic             abort,
   output logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] ext,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam int SH_W  = $clog2(WIDTH);
   localparam int CNT_W = SH_W + 1;

   state_t           r_state, w_nxt_state;
   logic [WIDTH-1:0] r_acc, w_acc;
   logic [WIDTH-1:0] r_ext, w_ext;
   logic [3:0]       r_flags, w_flags;
   logic             r_done, w_done;
   logic             w_load, w_step, w_set_zn;
   logic [CNT_W-1:0] w_cnt;
   logic [WIDTH:0]   w_cin, w_sum, w_dif;
   logic [WIDTH-1:0] w_nxt_hi, w_nxt_lo;
   logic             w_nxt_out, w_last;

   alu_iter_unit #(.WIDTH(WIDTH), .OP_W(OP_W), .CNT_W(CNT_W)) u_iter (
      .clk       (clk),
      .arst      (arst),
      .i_load    (w_load),
      .i_step    (w_step),
      .i_op      (op),
      .i_a       (r_acc),
      .i_b       (operand),
      .i_cnt     (w_cnt),
      .o_nxt_hi  (w_nxt_hi),
      .o_nxt_lo  (w_nxt_lo),
      .o_nxt_out (w_nxt_out),
      .o_last    (w_last)
   );

   always_comb begin
      w_nxt_state = r_state;
      w_acc       = r_acc;
      w_ext       = r_ext;
      w_flags     = r_flags;
      w_done      = 1'b0;
      w_load      = 1'b0;
      w_step      = 1'b0;
      w_set_zn    = 1'b0;
      w_cnt       = '0;
      w_cin       = {{WIDTH{1'b0}}, r_flags[FLG_C]};
      w_sum       = {1'b0, r_acc} + {1'b0, operand} + ((op == OP_ADDC) ? w_cin : '0);
      w_dif       = {1'b0, r_acc} - {1'b0, operand} - ((op == OP_SUBC) ? w_cin : '0);
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_done = 1'b1;
               case (op)
                  OP_LOAD: begin
                     w_acc    = operand;
                     w_set_zn = 1'b1;
                  end
                  OP_ADD, OP_ADDC: begin
                     w_acc          = w_sum[WIDTH-1:0];
                     w_flags[FLG_C] = w_sum[WIDTH];
                     w_flags[FLG_V] = (r_acc[WIDTH-1] == operand[WIDTH-1]) &&
                                      (w_sum[WIDTH-1] != r_acc[WIDTH-1]);
                     w_set_zn       = 1'b1;
                  end
                  OP_SUB, OP_SUBC: begin
                     w_acc          = w_dif[WIDTH-1:0];
                     w_flags[FLG_C] = w_dif[WIDTH];
                     w_flags[FLG_V] = (r_acc[WIDTH-1] != operand[WIDTH-1]) &&
                                      (w_dif[WIDTH-1] != r_acc[WIDTH-1]);
                     w_set_zn       = 1'b1;
                  end
                  OP_NOR:  begin w_acc = ~(r_acc | operand); w_set_zn = 1'b1; end
                  OP_NAND: begin w_acc = ~(r_acc & operand); w_set_zn = 1'b1; end
                  OP_XOR:  begin w_acc =   r_acc ^ operand;  w_set_zn = 1'b1; end
                  OP_XNOR: begin w_acc = ~(r_acc ^ operand); w_set_zn = 1'b1; end
                  OP_MUL: begin
                     w_done      = 1'b0;
                     w_load      = 1'b1;
                     w_cnt       = CNT_W'(WIDTH);
                     w_nxt_state = ST_MUL;
                  end
                  OP_SHL, OP_SHR, OP_ASR, OP_ROL: begin
                     // A zero shift amount retires at once, refreshing only Z and N.
                     if (operand[SH_W-1:0] != '0) begin
                        w_done      = 1'b0;
                        w_load      = 1'b1;
                        w_cnt       = {1'b0, operand[SH_W-1:0]};
                        w_nxt_state = ST_SHIFT;
                     end else begin
                        w_set_zn = 1'b1;
                     end
                  end
                  default: ;
               endcase
            end
         end
         ST_MUL, ST_SHIFT: begin
            if (abort) begin
               w_nxt_state = ST_IDLE;
            end else begin
               w_step = 1'b1;
               if (w_last) begin
                  w_nxt_state = ST_IDLE;
                  w_done      = 1'b1;
                  w_acc       = w_nxt_lo;
                  if (r_state == ST_MUL) begin
                     w_ext          = w_nxt_hi;
                     w_flags[FLG_C] = 1'b0;
                     w_flags[FLG_V] = (w_nxt_hi != '0);
                     w_flags[FLG_Z] = ({w_nxt_hi, w_nxt_lo} == '0);
                     w_flags[FLG_N] = w_nxt_hi[WIDTH-1];
                  end else begin
                     w_flags[FLG_C] = w_nxt_out;
                     w_set_zn       = 1'b1;
                  end
               end
            end
         end
         default: w_nxt_state = ST_IDLE;
      endcase
      if (w_set_zn) begin
         w_flags[FLG_N] = w_acc[WIDTH-1];
         w_flags[FLG_Z] = (w_acc == '0);
      end
   end

   always_ff @(posedge clk or negedge arst) begin
      if (!arst) begin
         r_state <= ST_IDLE;
         r_acc   <= '0;
         r_ext   <= '0;
         r_flags <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_acc   <= w_acc;
         r_ext   <= w_ext;
         r_flags <= w_flags;
         r_done  <= w_done;
      end
   end

   assign acc   = r_acc;
   assign ext   = r_ext;
   assign flags = r_flags;
   assign busy  = (r_state != ST_IDLE);
   assign done  = r_done;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - directed self-checking bench for alu_seq at WIDTH=8
module tb_alu_seq;

   logic       clk = 1'b0;
   logic       arst = 1'b0;
   logic       start = 1'b0;
   logic [3:0] op = 4'd0;
   logic [7:0] operand = 8'd0;
   logic       abort = 1'b0;
   logic [7:0] acc;
   logic [7:0] ext;
   logic [3:0] flags;
   logic       busy;
   logic       done;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc;

   alu_seq #(.WIDTH(8), .OP_W(4)) dut (
      .clk     (clk),
      .arst    (arst),
      .start   (start),
      .op      (op),
      .operand (operand),
      .abort   (abort),
      .acc     (acc),
      .ext     (ext),
      .flags   (flags),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [3:0] t_op, input logic [7:0] t_opnd);
      @(negedge clk);
      start   = 1'b1;
      op      = t_op;
      operand = t_opnd;
      @(negedge clk);
      start   = 1'b0;
   endtask

   // Single-cycle op: done high one cycle after the accept, busy low, then done drops.
   task automatic single(input string tag, input logic [3:0] t_op, input logic [7:0] t_opnd,
                         input logic [7:0] e_acc, input logic [3:0] e_flg);
      issue(t_op, t_opnd);
      check_val({tag, "_done"}, done, 1);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_acc"}, acc, e_acc);
      check_val({tag, "_flags"}, flags, e_flg);
      @(negedge clk);
      check_val({tag, "_done_drop"}, done, 0);
   endtask

   task automatic multi(input string tag, input logic [3:0] t_op, input logic [7:0] t_opnd,
                        input int e_cyc, input logic [7:0] e_acc, input logic [3:0] e_flg);
      logic [7:0] hold;
      int n;
      hold = acc;
      issue(t_op, t_opnd);
      n = 0;
      while (busy && n < 100) begin
         check_val({tag, "_hold"}, acc, hold);
         check_val({tag, "_nodone"}, done, 0);
         @(negedge clk);
         n++;
      end
      check_val({tag, "_busy_cycles"}, n, e_cyc);
      check_val({tag, "_done"}, done, 1);
      check_val({tag, "_acc"}, acc, e_acc);
      check_val({tag, "_flags"}, flags, e_flg);
      @(negedge clk);
      check_val({tag, "_done_drop"}, done, 0);
   endtask

   initial begin
      #12;
      check_val("rst_acc", acc, 0);
      check_val("rst_ext", ext, 0);
      check_val("rst_flags", flags, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      @(negedge clk);
      arst = 1'b1;

      // flags are {N,Z,V,C}
      single("t1_load", 4'd1, 8'h7F, 8'h7F, 4'h0);
      single("t1_add",  4'd2, 8'h01, 8'h80, 4'hA);

      single("t2_load", 4'd1, 8'h00, 8'h00, 4'h6);
      single("t2_sub",  4'd4, 8'h01, 8'hFF, 4'h9);
      single("t2_subc", 4'd5, 8'h00, 8'hFE, 4'h8);
      single("t2_xor",  4'd8, 8'hFE, 8'h00, 4'h4);

      single("t3_load", 4'd1, 8'hC8, 8'hC8, 4'h8);
      multi("t3_mul", 4'd10, 8'h64, 8, 8'h20, 4'h2);
      check_val("t3_ext", ext, 8'h4E);

      single("t4_load1", 4'd1, 8'h81, 8'h81, 4'hA);
      multi("t4_rol3", 4'd14, 8'h03, 3, 8'h0C, 4'h2);
      single("t4_load2", 4'd1, 8'h90, 8'h90, 4'hA);
      multi("t4_asr2", 4'd13, 8'h02, 2, 8'hE4, 4'hA);
      single("t4_load3", 4'd1, 8'h81, 8'h81, 4'hA);
      multi("t4_shr1", 4'd12, 8'h01, 1, 8'h40, 4'h3);
      single("t4_shl0", 4'd11, 8'h00, 8'h40, 4'h3);
      single("rsvd_op", 4'd15, 8'h55, 8'h40, 4'h3);

      // Ignored start during busy, then abort sampled at the 4th iteration edge
      issue(4'd10, 8'h03);
      start = 1'b1; op = 4'd2; operand = 8'h01;
      @(negedge clk);
      start = 1'b0;
      check_val("t5_busy_after_ign", busy, 1);
      repeat (2) @(negedge clk);
      check_val("t5_busy_pre_abort", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("t5_abort_busy", busy, 0);
      check_val("t5_abort_done", done, 0);
      check_val("t5_abort_acc", acc, 8'h40);
      check_val("t5_abort_ext", ext, 8'h4E);
      check_val("t5_abort_flags", flags, 4'h3);
      single("t5_load", 4'd1, 8'h11, 8'h11, 4'h3);

      // Abort coinciding with the commit edge suppresses the commit
      issue(4'd10, 8'h02);
      repeat (7) @(negedge clk);
      check_val("ab_commit_busy_pre", busy, 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check_val("ab_commit_busy", busy, 0);
      check_val("ab_commit_done", done, 0);
      check_val("ab_commit_acc", acc, 8'h11);
      check_val("ab_commit_ext", ext, 8'h4E);

      // Asynchronous reset mid-multiply
      issue(4'd10, 8'h07);
      repeat (2) @(negedge clk);
      #2 arst = 1'b0;
      #1;
      check_val("t6_acc", acc, 0);
      check_val("t6_ext", ext, 0);
      check_val("t6_flags", flags, 0);
      check_val("t6_busy", busy, 0);
      check_val("t6_done", done, 0);
      @(negedge clk);
      arst = 1'b1;
      single("t6_load", 4'd1, 8'h05, 8'h05, 4'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Second-generation accumulator ALU for the micro core. It is parametrised in WIDTH and adds multi-cycle operations: an iterative unsigned multiply into an extension register, and variable-amount shifts and rotates. A start/busy/done handshake lets the control unit stall on long operations. Single-cycle operations keep the accumulator/flags programming model.

Parameters:
WIDTH, 8, datapath width; power of two, 4..32.
OP_W, 4, opcode width.
SH_W, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
clk  in  1  clock, rising edge.
arst  in  1  asynchronous reset, active-low (0 = reset).
start  in  1  request; sampled only when busy=0.
op  in  OP_W  opcode from alu_seq_pkg, sampled with start.
operand  in  WIDTH  second operand, already selected by the control unit (memory or immediate).
abort  in  1  synchronous cancel of an in-flight multi-cycle operation.
acc  out  WIDTH  accumulator.
ext  out  WIDTH  extension register (high half of the product).
flags  out  4  {NEG, ZERO, OV, CARRY}; bit indices are defined in the package.
busy  out  1  multi-cycle operation in progress.
done  out  1  one-cycle pulse when an accepted operation commits.

Behaviour:
- Reset (arst=0, asynchronous): acc=0, ext=0, flags=0, busy=0, done=0, FSM=IDLE. Reset mid-operation discards the operation.
- FSM states: IDLE, MUL, SHIFT. done is registered. It defaults to 0 each cycle and is set only on commit.
- Single-cycle ops are accepted in IDLE. Results and flags commit at the accepting edge, done=1 for the following cycle, and busy stays 0.
  - NOP: nothing changes except done.
  - LOAD: acc=operand; Z and N updated; C and V kept.
  - ADD / ADDC: {C,acc} = acc + operand (+C). V = operand signs equal and result sign differs.
  - SUB / SUBC: {C,acc} = acc − operand (−C); C = borrow (bit WIDTH of the extended difference). V = operand signs differ and result sign differs from old acc.
  - NOR / NAND / XOR / XNOR: Z and N updated; C and V kept.
  - In every case above where Z and N are updated: N = result[WIDTH-1] and Z = (result==0).
- MUL (multi-cycle): at the accepting edge, working regs load and the FSM goes to MUL with busy=1.
  - One shift-add iteration per cycle, WIDTH iterations.
  - On the WIDTH-th edge after acceptance: {ext,acc} = acc*operand (unsigned), C=0, V=(ext≠0), Z=(full 2·WIDTH product==0), N=ext[WIDTH-1]. busy→0 and done=1 next cycle. Latency is exactly WIDTH edges.
- SHL / SHR / ASR / ROL (multi-cycle): amount n = operand[SH_W-1:0], one bit per cycle.
  - n=0: treated as a single-cycle op. acc and C unchanged; Z and N updated.
  - n≥1: commit on the n-th edge. C = last bit shifted or rotated out, V kept, Z and N updated.
  - SHR and SHL fill with 0; ASR replicates the MSB.
- acc, ext and flags hold their old values until commit. Intermediates live in internal working registers only.
- start while busy=1 is ignored: no queueing and no effect on the operation in flight.
- abort with busy=1: return to IDLE at that edge, no commit, no done. abort in IDLE has no effect.
- abort and the commit edge in the same cycle: abort wins and no commit occurs.
- Any opcode not defined in the package behaves as NOP (done still pulses).

Decomposition:
- alu_seq_pkg holds:
  - opcode constants: NOP 0, LOAD 1, ADD 2, ADDC 3, SUB 4, SUBC 5, NOR 6, NAND 7, XOR 8, XNOR 9, MUL 10, SHL 11, SHR 12, ASR 13, ROL 14, 15 reserved;
  - flag bit indices: CARRY 0, OV 1, ZERO 2, NEG 3;
  - FSM state encoding.
- One sub-module, alu_iter_unit, holds the iterative multiply/shift engine: working regs, iteration counter, and last-out bit.
- alu_seq keeps the combinational single-cycle datapath, the FSM, and the architectural registers.

Test Plan:
1. WIDTH=8: LOAD 0x7F, then ADD 0x01 → acc=0x80, V=1, N=1, C=0, Z=0; done pulses one cycle after each start; busy stays 0.
2. LOAD 0x00, then SUB 0x01 → acc=0xFF, C=1, N=1; then SUBC 0x00 → acc=0xFE, C=0; then XOR 0xFE → acc=0x00, Z=1, C unchanged.
3. LOAD 0xC8, then MUL 0x64 → busy high for 8 cycles, acc holds 0xC8 throughout; then ext=0x4E, acc=0x20, V=1, C=0, Z=0, N=0, single done pulse.
4. LOAD 0x81, then ROL 3 → acc=0x0C, C=0, after 3 edges. LOAD 0x90, then ASR 2 → acc=0xE4, N=1, C=0. LOAD 0x81, then SHR 1 → acc=0x40, C=1. SHL 0 → acc unchanged, single-cycle.
5. Start MUL, re-pulse start with ADD during busy → ignored. Assert abort at iteration 4 → acc, ext and flags unchanged, no done, busy=0. Next LOAD is accepted immediately.
6. Start MUL, drive arst=0 asynchronously mid-operation → acc, ext, flags, busy and done go to 0 without waiting for a clock edge. After release, LOAD 0x05 → acc=0x05.
